// File: rtl/int_sched_ctl.sv
// Interrupt scheduler: synchronises seven discrete interrupt lines, captures
// rising edges, latches them into a pending register on each sampling strobe,
// and raises SINT to the computer with a read/clear/lockout handshake.
module int_sched_ctl #(
  parameter int unsigned LOCKOUT = 4
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic [6:0] INTR,
  input  logic       PHASE_STB,
  input  logic       INHB_WE,
  input  logic [6:0] INHB_D,
  input  logic       RST_WE,
  input  logic [6:0] RST_D,
  input  logic       RD_REQ,
  output logic [6:0] RD_DATA,
  output logic       RD_ACK,
  output logic       SINT,
  output logic [6:0] PEND,
  output logic [2:0] ID
);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAITCLR, LOCK} state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic [6:0] sync1, sync2, hist;
  logic [1:0] warm;
  logic [6:0] edges;
  logic [6:0] cap;
  logic [6:0] inhb;
  logic [6:0] pend, pend_next;
  logic [6:0] set_bits, clr_bits;
  logic [6:0] rd_data;
  logic       rd_ack;

  // Two-flop synchroniser plus edge history, with a warm-up count after reset.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      warm  <= '0;
    end else begin
      sync1 <= INTR;
      sync2 <= sync1;
      hist  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Edges are only trusted once the history flop holds a post-reset sample,
  // so a line already high at reset release is not seen as a new edge.
  always_comb begin
    edges = (warm == 2'd3) ? (sync2 & ~hist) : '0;
  end

  // Pending set/clear terms; a set of a bit overrides a clear in the same cycle.
  always_comb begin
    set_bits  = PHASE_STB ? (cap & ~inhb) : '0;
    clr_bits  = RST_WE ? RST_D : '0;
    pend_next = (pend & ~clr_bits) | set_bits;
  end

  // Capture, pending, inhibit mask and read snapshot registers.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      cap     <= '0;
      pend    <= '0;
      inhb    <= '0;
      rd_data <= '0;
      rd_ack  <= 1'b0;
    end else begin
      cap    <= PHASE_STB ? edges : (cap | edges);
      pend   <= pend_next;
      rd_ack <= RD_REQ;
      if (INHB_WE) inhb <= INHB_D;
      if (RD_REQ) rd_data <= pend;
    end
  end

  // FSM state and lockout counter register.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FSM next-state and lockout counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (pend != '0) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (RD_REQ) state_next = WAITCLR;
        else if (RST_WE && (pend_next == '0)) state_next = IDLE;
      end
      WAITCLR: begin
        if (RST_WE) begin
          state_next = LOCK;
          cnt_next   = 4'(LOCKOUT - 1);
        end
      end
      LOCK: begin
        if (cnt == '0) state_next = IDLE;
        else cnt_next = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Priority encode: lowest-numbered pending bit wins, 0 means none pending.
  always_comb begin
    ID = '0;
    for (int unsigned i = 7; i > 0; i--) begin
      if (pend[i-1]) ID = 3'(i);
    end
  end

  // Output assignments.
  always_comb begin
    SINT    = (state == ACTIVE);
    PEND    = pend;
    RD_DATA = rd_data;
    RD_ACK  = rd_ack;
  end

endmodule

// File: tb/tb_int_sched_ctl.sv
// Directed bench for int_sched_ctl: read responses go through a scoreboard
// queue checked by a monitor on RD_ACK; level outputs are checked in line.
module tb_int_sched_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] intr;
  logic       stb;
  logic       inhb_we;
  logic [6:0] inhb_d;
  logic       rst_we;
  logic [6:0] rst_d;
  logic       rd_req;
  logic [6:0] rd_data;
  logic       rd_ack;
  logic       sint;
  logic [6:0] pend;
  logic [2:0] id;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [6:0]  exp_q[$];

  int_sched_ctl #(.LOCKOUT(4)) dut (
    .SIM_CLK  (clk),
    .SIM_RST  (rst),
    .INTR     (intr),
    .PHASE_STB(stb),
    .INHB_WE  (inhb_we),
    .INHB_D   (inhb_d),
    .RST_WE   (rst_we),
    .RST_D    (rst_d),
    .RD_REQ   (rd_req),
    .RD_DATA  (rd_data),
    .RD_ACK   (rd_ack),
    .SINT     (sint),
    .PEND     (pend),
    .ID       (id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe();
    stb = 1'b1;
    cyc(1);
    stb = 1'b0;
  endtask

  task automatic raise(input logic [6:0] m);
    intr = intr | m;
    cyc(3);
  endtask

  task automatic lower_all();
    intr = '0;
    cyc(3);
  endtask

  task automatic clear(input logic [6:0] m);
    rst_we = 1'b1;
    rst_d  = m;
    cyc(1);
    rst_we = 1'b0;
    rst_d  = '0;
  endtask

  task automatic read(input logic [6:0] expect_val);
    exp_q.push_back(expect_val);
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
  endtask

  task automatic write_inhb(input logic [6:0] m);
    inhb_we = 1'b1;
    inhb_d  = m;
    cyc(1);
    inhb_we = 1'b0;
  endtask

  // Scoreboard monitor: every RD_ACK pops one expected snapshot.
  always @(negedge clk) begin
    if (rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_ack_unexpected: got RD_ACK=1 with data 0x%0h, expected no acknowledge", rd_data);
      end else begin
        chk("rd_data", 8'(rd_data), 8'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; intr = '0; stb = 1'b0; inhb_we = 1'b0; inhb_d = '0;
    rst_we = 1'b0; rst_d = '0; rd_req = 1'b0;
    cyc(2);
    chk("rst_pend", 8'(pend), 8'h00);
    chk("rst_id", 8'(id), 8'h00);
    chk("rst_sint", 8'(sint), 8'h00);
    chk("rst_rd_ack", 8'(rd_ack), 8'h00);
    chk("rst_rd_data", 8'(rd_data), 8'h00);
    rst = 1'b0;
    cyc(4);

    // INTR3 rises, strobe latches it, SINT follows one cycle later.
    raise(7'h04);
    strobe();
    chk("t1_pend", 8'(pend), 8'h04);
    chk("t1_id", 8'(id), 8'd3);
    chk("t1_sint_pre", 8'(sint), 8'h00);
    cyc(1);
    chk("t1_sint", 8'(sint), 8'h01);
    clear(7'h04);
    chk("t1_clr_pend", 8'(pend), 8'h00);
    chk("t1_clr_sint", 8'(sint), 8'h00);
    lower_all();

    // Inhibited bit 0 is discarded at the strobe and never returns.
    write_inhb(7'h01);
    raise(7'h11);
    strobe();
    chk("t2_pend", 8'(pend), 8'h10);
    chk("t2_id", 8'(id), 8'd5);
    write_inhb(7'h00);
    strobe();
    chk("t2_pend_after_uninhibit", 8'(pend), 8'h10);
    clear(7'h10);
    lower_all();

    // Read, clear, lockout, then re-assertion with the remaining bit.
    raise(7'h05);
    strobe();
    chk("t3_pend", 8'(pend), 8'h05);
    cyc(1);
    chk("t3_sint_active", 8'(sint), 8'h01);
    read(7'h05);
    chk("t3_sint_waitclr", 8'(sint), 8'h00);
    cyc(1);
    clear(7'h01);
    chk("t3_pend_cleared", 8'(pend), 8'h04);
    cyc(4);
    chk("t3_sint_lock", 8'(sint), 8'h00);
    cyc(1);
    chk("t3_sint_reassert", 8'(sint), 8'h01);
    chk("t3_id", 8'(id), 8'd3);
    clear(7'h04);
    lower_all();

    // New edges keep latching while waiting for the clear.
    raise(7'h02);
    strobe();
    cyc(1);
    read(7'h02);
    raise(7'h40);
    strobe();
    chk("t4_pend", 8'(pend), 8'h42);
    chk("t4_sint_waitclr", 8'(sint), 8'h00);
    clear(7'h02);
    chk("t4_pend_cleared", 8'(pend), 8'h40);
    cyc(4);
    chk("t4_sint_lock", 8'(sint), 8'h00);
    cyc(1);
    chk("t4_sint_reassert", 8'(sint), 8'h01);
    chk("t4_id", 8'(id), 8'd7);
    clear(7'h40);
    lower_all();

    // Set beats clear in one cycle; read with clear returns pre-clear value.
    raise(7'h02);
    stb = 1'b1; rst_we = 1'b1; rst_d = 7'h02;
    cyc(1);
    stb = 1'b0; rst_we = 1'b0; rst_d = '0;
    chk("t5_set_wins", 8'(pend), 8'h02);
    cyc(1);
    chk("t5_sint", 8'(sint), 8'h01);
    exp_q.push_back(7'h02);
    rd_req = 1'b1; rst_we = 1'b1; rst_d = 7'h02;
    cyc(1);
    rd_req = 1'b0; rst_we = 1'b0; rst_d = '0;
    chk("t5_pend_after_rdclr", 8'(pend), 8'h00);
    chk("t5_sint_after_rdclr", 8'(sint), 8'h00);
    clear(7'h00);
    cyc(5);
    read(7'h00);
    chk("t5_sint_idle_read", 8'(sint), 8'h00);
    lower_all();

    // Reset in LOCK with INTR held high: immediate clear, no stale edge.
    raise(7'h08);
    strobe();
    cyc(1);
    read(7'h08);
    clear(7'h00);
    chk("t6_pend_lock", 8'(pend), 8'h08);
    chk("t6_rd_data_lock", 8'(rd_data), 8'h08);
    chk("t6_sint_lock", 8'(sint), 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_pend", 8'(pend), 8'h00);
    chk("t6_async_id", 8'(id), 8'h00);
    chk("t6_async_rd_data", 8'(rd_data), 8'h00);
    chk("t6_async_sint", 8'(sint), 8'h00);
    chk("t6_async_rd_ack", 8'(rd_ack), 8'h00);
    @(posedge clk); #1;
    cyc(1);
    rst = 1'b0;
    cyc(6);
    strobe();
    chk("t6_no_stale_edge", 8'(pend), 8'h00);
    lower_all();
    raise(7'h08);
    strobe();
    chk("t6_new_edge", 8'(pend), 8'h08);

    cyc(3);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
